// File: rtl/cachepool_pkg.sv
// Shared types for the CachePool L1 refill path: line request/response records,
// the tile's wide AXI master channel types and the refill engine state encoding.
package cachepool_pkg;

    localparam int unsigned SpatzAxiDataWidth = 256;
    localparam int unsigned SpatzAxiAddrWidth = 32;
    localparam int unsigned SpatzAxiIdWidth   = 6;
    localparam int unsigned SpatzAxiUserWidth = 1;
    localparam int unsigned L1LineWidth       = 512;

    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [1:0] AxiRespOkay  = 2'b00;

    typedef struct packed {
        logic                           we;
        logic [SpatzAxiAddrWidth-1:0]   addr;
        logic [L1LineWidth-1:0]         data;
    } refill_req_t;

    typedef struct packed {
        logic [L1LineWidth-1:0] data;
        logic                   err;
    } refill_rsp_t;

    // Common AR/AW address channel payload.
    typedef struct packed {
        logic [SpatzAxiIdWidth-1:0]     id;
        logic [SpatzAxiAddrWidth-1:0]   addr;
        logic [7:0]                     len;
        logic [2:0]                     size;
        logic [1:0]                     burst;
        logic                           lock;
        logic [3:0]                     cache;
        logic [2:0]                     prot;
        logic [3:0]                     qos;
        logic [3:0]                     region;
        logic [SpatzAxiUserWidth-1:0]   user;
    } spatz_axi_out_ax_chan_t;

    typedef struct packed {
        logic [SpatzAxiDataWidth-1:0]   data;
        logic [SpatzAxiDataWidth/8-1:0] strb;
        logic                           last;
        logic [SpatzAxiUserWidth-1:0]   user;
    } spatz_axi_out_w_chan_t;

    typedef struct packed {
        logic [SpatzAxiIdWidth-1:0]     id;
        logic [1:0]                     resp;
        logic [SpatzAxiUserWidth-1:0]   user;
    } spatz_axi_out_b_chan_t;

    typedef struct packed {
        logic [SpatzAxiIdWidth-1:0]     id;
        logic [SpatzAxiDataWidth-1:0]   data;
        logic [1:0]                     resp;
        logic                           last;
        logic [SpatzAxiUserWidth-1:0]   user;
    } spatz_axi_out_r_chan_t;

    typedef struct packed {
        spatz_axi_out_ax_chan_t aw;
        logic                   aw_valid;
        spatz_axi_out_w_chan_t  w;
        logic                   w_valid;
        logic                   b_ready;
        spatz_axi_out_ax_chan_t ar;
        logic                   ar_valid;
        logic                   r_ready;
    } spatz_axi_out_req_t;

    typedef struct packed {
        logic                   aw_ready;
        logic                   ar_ready;
        logic                   w_ready;
        logic                   b_valid;
        spatz_axi_out_b_chan_t  b;
        logic                   r_valid;
        spatz_axi_out_r_chan_t  r;
    } spatz_axi_out_resp_t;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StAw,
        StW,
        StB,
        StRsp
    } refill_state_e;

endpackage

// File: rtl/cachepool_refill_unit.sv
// Single-outstanding cache-line refill/writeback engine on the tile's wide AXI port.
// One line buffer serves both read-beat assembly and writeback data.
module cachepool_refill_unit
    import cachepool_pkg::*;
#(
    parameter int unsigned LineWidth    = L1LineWidth,
    parameter int unsigned AxiDataWidth = SpatzAxiDataWidth,
    parameter int unsigned AddrWidth    = SpatzAxiAddrWidth,
    parameter int unsigned NumBeats     = LineWidth / AxiDataWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic [LineWidth-1:0]    req_data_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [LineWidth-1:0]    rsp_data_o,
    output logic                    rsp_err_o,
    output spatz_axi_out_req_t      axi_req_o,
    input  spatz_axi_out_resp_t     axi_rsp_i
);

    localparam int unsigned OffBits  = $clog2(LineWidth / 8);
    localparam int unsigned CntWidth = $clog2(NumBeats) + 1;
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(NumBeats - 1);
    localparam logic [CntWidth-1:0] CntSat   = CntWidth'(NumBeats);
    localparam logic [2:0]          AxSize   = 3'($clog2(AxiDataWidth / 8));

    refill_state_e          state_q, state_d;
    logic [LineWidth-1:0]   line_q, line_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [CntWidth-1:0]    beat_q, beat_d;
    logic                   err_q, err_d;

    logic [AxiDataWidth-1:0] w_data;
    spatz_axi_out_ax_chan_t  ax;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            line_q  <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = {req_addr_i[AddrWidth-1:OffBits], OffBits'(0)};
                    line_d  = req_data_i;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = req_we_i ? StAw : StAr;
                end
            end
            StAr: begin
                if (axi_rsp_i.ar_ready) state_d = StR;
            end
            StR: begin
                if (axi_rsp_i.r_valid) begin
                    // Beats beyond the line match no slot and are dropped.
                    for (int unsigned i = 0; i < NumBeats; i++) begin
                        if (beat_q == CntWidth'(i)) begin
                            line_d[i*AxiDataWidth +: AxiDataWidth] =
                                axi_rsp_i.r.data[AxiDataWidth-1:0];
                        end
                    end
                    if (beat_q != CntSat) beat_d = beat_q + CntWidth'(1);
                    if (axi_rsp_i.r.resp != AxiRespOkay) err_d = 1'b1;
                    if (axi_rsp_i.r.last) begin
                        if (beat_q != LastBeat) err_d = 1'b1;
                        state_d = StRsp;
                    end else if (beat_q >= LastBeat) begin
                        err_d = 1'b1;
                    end
                end
            end
            StAw: begin
                if (axi_rsp_i.aw_ready) state_d = StW;
            end
            StW: begin
                if (axi_rsp_i.w_ready) begin
                    beat_d = beat_q + CntWidth'(1);
                    if (beat_q == LastBeat) state_d = StB;
                end
            end
            StB: begin
                if (axi_rsp_i.b_valid) begin
                    if (axi_rsp_i.b.resp != AxiRespOkay) err_d = 1'b1;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        w_data = '0;
        for (int unsigned i = 0; i < NumBeats; i++) begin
            if (beat_q == CntWidth'(i)) w_data = line_q[i*AxiDataWidth +: AxiDataWidth];
        end
    end

    always_comb begin
        ax       = '0;
        ax.addr  = SpatzAxiAddrWidth'(addr_q);
        ax.len   = 8'(NumBeats - 1);
        ax.size  = AxSize;
        ax.burst = AxiBurstIncr;
        ax.cache = 4'b0011;
    end

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.ar       = ax;
        axi_req_o.aw       = ax;
        axi_req_o.ar_valid = (state_q == StAr);
        axi_req_o.r_ready  = (state_q == StR);
        axi_req_o.aw_valid = (state_q == StAw);
        axi_req_o.w_valid  = (state_q == StW);
        axi_req_o.w.data   = SpatzAxiDataWidth'(w_data);
        axi_req_o.w.strb   = '1;
        axi_req_o.w.last   = (beat_q == LastBeat);
        axi_req_o.b_ready  = (state_q == StB);
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StRsp);
    assign rsp_data_o  = line_q;
    assign rsp_err_o   = err_q;

    logic unused_sigs;
    assign unused_sigs = ^{req_addr_i[OffBits-1:0], axi_rsp_i.r.id, axi_rsp_i.r.user,
                           axi_rsp_i.b.id, axi_rsp_i.b.user};

endmodule

// File: tb/tb_cachepool_refill_unit.sv
// Randomised bench for cachepool_refill_unit: an AXI slave model drives the bus while a
// per-cycle compare process checks handshakes, payloads and completions against a line model.
module tb_cachepool_refill_unit;
    import cachepool_pkg::*;

    localparam int NB = 2;
    localparam int DW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                req_valid, req_ready, req_we;
    logic [31:0]         req_addr;
    logic [511:0]        req_data;
    logic                rsp_valid, rsp_ready, rsp_err;
    logic [511:0]        rsp_data;
    spatz_axi_out_req_t  axi_req;
    spatz_axi_out_resp_t axi_rsp;

    cachepool_refill_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .axi_req_o   (axi_req),
        .axi_rsp_i   (axi_rsp)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model state.
    bit           run_cmp = 0;
    bit           busy = 0, exp_we = 0, ar_done = 0, aw_done = 0, bus_done = 0;
    int           w_cnt = 0;
    logic [31:0]  exp_addr;
    logic [511:0] exp_wdata, exp_rdata, exp_mask;
    logic         exp_err;

    // Slave knobs.
    int           ar_dly, aw_dly, b_dly, wr_mode, rsp_hold, abort_beat, rlast_at;
    bit           r_gaps;
    logic [255:0] rbeat [4];
    logic [1:0]   rresp_a [4];
    logic [1:0]   bresp_v;

    // Per-transaction captures.
    logic [31:0]  cap_ar_addr, cap_aw_addr;
    logic [7:0]   cap_len;
    logic [2:0]   cap_size;
    logic [255:0] cap_w [2];
    logic         cap_wlast [2];
    int           rsp_cyc;
    logic [511:0] got_data;
    logic         got_err;

    always @(negedge clk) begin
        if (!rst && run_cmp) begin
            check_eq("req_ready", req_ready, !busy);
            check_eq("ar_valid", axi_req.ar_valid, busy && !exp_we && !ar_done);
            check_eq("r_ready", axi_req.r_ready, busy && !exp_we && ar_done && !bus_done);
            check_eq("aw_valid", axi_req.aw_valid, busy && exp_we && !aw_done);
            check_eq("w_valid", axi_req.w_valid, busy && exp_we && aw_done && w_cnt < NB);
            check_eq("b_ready", axi_req.b_ready, busy && exp_we && w_cnt == NB && !bus_done);
            check_eq("rsp_valid", rsp_valid, busy && bus_done);
            if (axi_req.ar_valid)
                check_eq("ar_payload", {axi_req.ar.addr, axi_req.ar.len, axi_req.ar.size,
                         axi_req.ar.burst, axi_req.ar.cache, axi_req.ar.id, axi_req.ar.prot,
                         axi_req.ar.user},
                         {exp_addr, 8'd1, 3'd5, 2'b01, 4'b0011, 6'd0, 3'd0, 1'b0});
            if (axi_req.aw_valid)
                check_eq("aw_payload", {axi_req.aw.addr, axi_req.aw.len, axi_req.aw.size,
                         axi_req.aw.burst, axi_req.aw.cache, axi_req.aw.id, axi_req.aw.prot,
                         axi_req.aw.user},
                         {exp_addr, 8'd1, 3'd5, 2'b01, 4'b0011, 6'd0, 3'd0, 1'b0});
            if (axi_req.w_valid && w_cnt < NB)
                check_eq("w_payload", {axi_req.w.data, axi_req.w.strb, axi_req.w.last},
                         {exp_wdata[w_cnt*DW +: DW], 32'hFFFF_FFFF, 1'(w_cnt == NB - 1)});
            if (rsp_valid && busy && bus_done) begin
                check_eq("rsp_err", rsp_err, exp_err);
                if (!exp_we) check_eq("rsp_data", rsp_data & exp_mask, exp_rdata & exp_mask);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        busy = 0; ar_done = 0; aw_done = 0; bus_done = 0; w_cnt = 0;
    endtask

    task automatic recover();
        axi_rsp = '0; rsp_ready = 0; req_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        clear_model();
    endtask

    task automatic set_defaults();
        ar_dly = 0; aw_dly = 0; b_dly = 0; wr_mode = 0; rsp_hold = 0; abort_beat = -1;
        r_gaps = 0; rlast_at = 1; bresp_v = 2'b00;
        for (int k = 0; k < 4; k++) begin
            rbeat[k]   = {8{$urandom}};
            rresp_a[k] = 2'b00;
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [511:0] data);
        int cyc, arw, aww, bw, hold, r_sent;
        bit r_pend, b_pend, hs_ar, hs_r, hs_aw, hs_w, hs_b, hs_rsp, r_last_now, aborted;
        // Expected outcome from the line-transfer rules.
        exp_addr  = addr & 32'hFFFF_FFC0;
        exp_we    = we;
        exp_wdata = data;
        exp_rdata = '0;
        exp_mask  = '0;
        exp_err   = 0;
        if (!we) begin
            for (int k = 0; k <= rlast_at; k++) begin
                if (k < NB) begin
                    exp_rdata[k*DW +: DW] = rbeat[k];
                    exp_mask[k*DW +: DW]  = '1;
                end
                if (rresp_a[k] != 2'b00) exp_err = 1;
            end
            if (rlast_at != NB - 1) exp_err = 1;
        end else begin
            exp_err = (bresp_v != 2'b00);
        end
        req_valid = 1; req_we = we; req_addr = addr; req_data = data;
        cyc = 0;
        while (!req_ready && cyc < 20) begin tick(); cyc++; end
        if (!req_ready) begin
            check_eq("req_accept_timeout", 0, 1);
            recover();
            return;
        end
        tick();
        clear_model();
        busy = 1;
        req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_data = {16{$urandom}};
        cyc = 1; arw = 0; aww = 0; bw = 0; hold = 0; r_sent = 0;
        r_pend = 0; b_pend = 0; aborted = 0; rsp_cyc = -1;
        while (busy && cyc < 400) begin
            axi_rsp = '0;
            rsp_ready = 0;
            if (axi_req.ar_valid) begin
                axi_rsp.ar_ready = (ar_dly < 0) ? 1'($urandom) : (arw >= ar_dly);
                arw++;
            end
            if (ar_done && r_sent <= rlast_at && !exp_we) begin
                r_pend = r_pend || !r_gaps || ($urandom_range(0, 2) != 0);
                if (r_pend) begin
                    axi_rsp.r_valid  = 1;
                    axi_rsp.r.data   = rbeat[r_sent];
                    axi_rsp.r.resp   = rresp_a[r_sent];
                    axi_rsp.r.last   = (r_sent == rlast_at);
                end
            end
            if (axi_req.aw_valid) begin
                axi_rsp.aw_ready = (aw_dly < 0) ? 1'($urandom) : (aww >= aw_dly);
                aww++;
            end
            if (axi_req.w_valid)
                axi_rsp.w_ready = (wr_mode == 0) ? 1'b1 :
                                  (wr_mode == 1) ? (cyc % 2 == 1) : 1'($urandom);
            if (exp_we && w_cnt == NB && !bus_done) begin
                b_pend = b_pend || (bw >= b_dly);
                bw++;
                if (b_pend) begin
                    axi_rsp.b_valid = 1;
                    axi_rsp.b.resp  = bresp_v;
                end
            end
            if (rsp_valid) begin
                if (rsp_cyc < 0) rsp_cyc = cyc;
                rsp_ready = (hold >= rsp_hold);
                hold++;
                got_data = rsp_data;
                got_err  = rsp_err;
            end
            if (abort_beat >= 0 && !exp_we && ar_done && r_sent == abort_beat) begin
                rst = 1;
                aborted = 1;
            end
            hs_ar  = axi_req.ar_valid && axi_rsp.ar_ready;
            hs_r   = axi_rsp.r_valid && axi_req.r_ready;
            r_last_now = axi_rsp.r.last;
            hs_aw  = axi_req.aw_valid && axi_rsp.aw_ready;
            hs_w   = axi_req.w_valid && axi_rsp.w_ready;
            hs_b   = axi_rsp.b_valid && axi_req.b_ready;
            hs_rsp = rsp_valid && rsp_ready;
            if (hs_ar) begin
                cap_ar_addr = axi_req.ar.addr;
                cap_len     = axi_req.ar.len;
                cap_size    = axi_req.ar.size;
            end
            if (hs_aw) cap_aw_addr = axi_req.aw.addr;
            if (hs_w && w_cnt < NB) begin
                cap_w[w_cnt]     = axi_req.w.data;
                cap_wlast[w_cnt] = axi_req.w.last;
            end
            tick();
            if (aborted) begin
                rst = 0;
                axi_rsp = '0;
                rsp_ready = 0;
                clear_model();
                return;
            end
            if (hs_ar) ar_done = 1;
            if (hs_r) begin
                r_pend = 0;
                r_sent++;
                if (r_last_now) bus_done = 1;
            end
            if (hs_aw) aw_done = 1;
            if (hs_w) w_cnt++;
            if (hs_b) begin bus_done = 1; b_pend = 0; end
            if (hs_rsp) busy = 0;
            cyc++;
        end
        axi_rsp = '0;
        rsp_ready = 0;
        if (busy) begin
            check_eq("txn_timeout", 0, 1);
            recover();
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d0, d1;
        rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_data = '0;
        rsp_ready = 0; axi_rsp = '0;
        set_defaults();
        tick(); tick(); tick();
        check_eq("reset_req_ready", req_ready, 1);
        check_eq("reset_rsp", {rsp_valid, rsp_err}, 2'b00);
        check_eq("reset_rsp_data", rsp_data, '0);
        check_eq("reset_axi_valids", {axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid,
                 axi_req.r_ready, axi_req.b_ready}, 5'b0);
        rst = 0;
        run_cmp = 1;
        tick();

        // Zero-wait refill with fixed beats.
        set_defaults();
        rbeat[0] = {32{8'hAA}};
        rbeat[1] = {32{8'hBB}};
        run_txn(0, 32'h5180_0040, {16{$urandom}});
        check_eq("t1_ar_addr", cap_ar_addr, 32'h5180_0040);
        check_eq("t1_ar_len_size", {cap_len, cap_size}, {8'd1, 3'd5});
        check_eq("t1_data", got_data, {{32{8'hBB}}, {32{8'hAA}}});
        check_eq("t1_err", got_err, 0);
        check_eq("t1_rsp_cycle", rsp_cyc, 4);

        set_defaults();
        run_txn(0, 32'h5180_007C, {16{$urandom}});
        check_eq("t2_aligned_addr", cap_ar_addr, 32'h5180_0040);

        // Writeback with slow AW and toggling W ready.
        set_defaults();
        d0 = {32{8'hD0}};
        d1 = {32{8'hD1}};
        aw_dly = 3; wr_mode = 1; b_dly = 1;
        run_txn(1, 32'h8000_0000, {d1, d0});
        check_eq("t3_aw_addr", cap_aw_addr, 32'h8000_0000);
        check_eq("t3_w0", cap_w[0], d0);
        check_eq("t3_w1", cap_w[1], d1);
        check_eq("t3_wlast", {cap_wlast[0], cap_wlast[1]}, 2'b01);
        check_eq("t3_err", got_err, 0);

        set_defaults();
        run_txn(1, 32'h8000_0100, {16{$urandom}});
        check_eq("t3b_wb_rsp_cycle", rsp_cyc, 5);

        set_defaults();
        rresp_a[0] = 2'b10;
        run_txn(0, 32'h1000_0000, {16{$urandom}});
        check_eq("t4_slverr", got_err, 1);
        set_defaults();
        run_txn(0, 32'h1000_0040, {16{$urandom}});
        check_eq("t4_okay_after_err", got_err, 0);

        set_defaults();
        rlast_at = 0;
        run_txn(0, 32'h2000_0000, {16{$urandom}});
        check_eq("t5_early_rlast_err", got_err, 1);
        check_eq("t5_back_idle", req_ready, 1);

        // Long completion hold, then reset during read data phase.
        set_defaults();
        rbeat[0] = {8{32'h1234_5678}};
        rbeat[1] = {8{32'h9ABC_DEF0}};
        rsp_hold = 5;
        run_txn(0, 32'h3000_0080, {16{$urandom}});
        check_eq("t6_hold_data", got_data, {{8{32'h9ABC_DEF0}}, {8{32'h1234_5678}}});
        set_defaults();
        abort_beat = 1;
        run_txn(0, 32'h3000_00C0, {16{$urandom}});
        check_eq("t6_abort_req_ready", req_ready, 1);
        check_eq("t6_abort_valids", {axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid,
                 axi_req.r_ready, axi_req.b_ready, rsp_valid}, 6'b0);

        for (int n = 0; n < 40; n++) begin
            int sel;
            set_defaults();
            ar_dly   = int'($urandom_range(0, 4)) - 1;
            aw_dly   = int'($urandom_range(0, 4)) - 1;
            b_dly    = int'($urandom_range(0, 3));
            wr_mode  = int'($urandom_range(0, 2));
            rsp_hold = int'($urandom_range(0, 3));
            r_gaps   = 1'($urandom);
            sel = int'($urandom_range(0, 7));
            rlast_at = (sel == 0) ? 0 : (sel == 1) ? 2 : 1;
            for (int k = 0; k < 4; k++)
                rresp_a[k] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bresp_v = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(1'($urandom), $urandom, {16{$urandom}});
        end

        tick(); tick();
        run_cmp = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cachepool_refill_unit.md
# cachepool_refill_unit

Refill/writeback engine between the CachePool L1 cache controller and the tile's wide AXI master port (`spatz_axi_out`, 256-bit data, 32-bit address). It accepts one cache-line request at a time from the L1 miss handler. Reads become AXI INCR read bursts that assemble a full line. Writebacks become AXI INCR write bursts, and the unit returns a completion with an error flag. There is a single outstanding transaction; the L1 miss handler serialises requests.

## Interface
Parameters:
- `LineWidth`, default 512: cache line width in bits; must be a multiple of `SpatzAxiDataWidth`.
- `AxiDataWidth`, default `SpatzAxiDataWidth` (256): AXI beat width.
- `AddrWidth`, default `SpatzAxiAddrWidth` (32): address width.
- `NumBeats`, default `LineWidth/AxiDataWidth` (2): derived; do not override.

Ports:
- `clk_i`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst_i`  in  1  synchronous active-high reset.
- `req_valid_i`  in  1  line request valid.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `req_we_i`  in  1  1 = writeback, 0 = refill.
- `req_addr_i`  in  AddrWidth  line address; low `$clog2(LineWidth/8)` bits are ignored and forced to 0.
- `req_data_i`  in  LineWidth  writeback line; beat 0 is bits [AxiDataWidth-1:0].
- `rsp_valid_o`  out  1  completion valid.
- `rsp_ready_i`  in  1  completion consumed.
- `rsp_data_o`  out  LineWidth  refilled line; undefined for writebacks.
- `rsp_err_o`  out  1  any beat or B response was not OKAY, or RLAST was misplaced.
- `axi_req_o`  out  `spatz_axi_out_req_t`  AXI master request.
- `axi_rsp_i`  in  `spatz_axi_out_resp_t`  AXI master response.

## Operation
- FSM states: IDLE, AR, R, AW, W, B, RSP.
- IDLE: `req_ready_o`=1. On handshake:
  - latch addr (aligned), we, and data;
  - clear the error flag and beat counter;
  - go to AR if `req_we_i`=0, otherwise AW.
- AR: `ar_valid`=1 with:
  - `ar.addr` = aligned addr, `ar.len` = NumBeats-1, `ar.size` = 5, `ar.burst` = INCR;
  - `ar.id` = 0, `ar.cache` = 4'b0011, `user` = 0, `prot` = 0.
  - On `ar_ready` go to R.
- R: `r_ready`=1.
  - Each beat is written into line slot `beat_cnt`, then `beat_cnt` increments.
  - `rresp`≠OKAY sets err.
  - `rlast` must appear exactly on beat NumBeats-1. If it arrives early, set err and go to RSP. If it is absent on the last beat, set err and keep consuming until `rlast`. Beats past NumBeats are discarded.
  - On `rlast` go to RSP.
- AW: `aw_valid`=1 with the same field values as AR. On `aw_ready` go to W. W is never issued before AW.
- W: `w_valid`=1.
  - `w.data` = slot `beat_cnt`, `w.strb` = all ones.
  - `w.last` is high when `beat_cnt`=NumBeats-1.
  - `beat_cnt` advances on `w_ready`. After the last beat go to B.
- B: `b_ready`=1. On `b_valid`, OR `bresp`≠OKAY into err and go to RSP.
- RSP: `rsp_valid_o`=1. `rsp_data_o` and `rsp_err_o` are held stable until `rsp_ready_i`, then go to IDLE.
- All AXI valids are held until their handshake, and their payloads are stable while valid.
- Reset mid-operation: immediately return to IDLE. All valids and readies go low next cycle, and the in-flight transaction is dropped. The system resets the interconnect with the same reset.

## Timing
- Reset values: `req_ready_o`=1, `rsp_valid_o`=0, `rsp_err_o`=0, `rsp_data_o`=0, all AXI valid/ready=0.
- All outputs come from registered state, with no combinational path from `req_valid_i` to any AXI signal.
- Refill latency with zero-wait AXI and NumBeats=2: request handshake at cycle 0, AR valid at cycle 1, R beats at cycles 2–3, `rsp_valid_o` at cycle 4.
- Writeback latency: AW at cycle 1, W at cycles 2–3, B at cycle 4, rsp at cycle 5.
- Back-to-back requests: the next request is accepted in the cycle after the RSP handshake, when the FSM is in IDLE.
- `req_ready_o`=0 in every state except IDLE.

## Structure
- In `cachepool_pkg`:
  - `L1LineWidth` (512);
  - `refill_req_t` {we, addr, data};
  - `refill_rsp_t` {data, err}.
- AXI types: `spatz_axi_out_req_t`/`_resp_t` from the package.
- No sub-module. The beat counter is `$clog2(NumBeats)+1` bits wide, and the line buffer is a single LineWidth register shared by read assembly and write data.

## Test plan
- Refill at 0x5180_0040, zero-wait AXI, R data 0xAAAA.., 0xBBBB.. → AR addr 0x5180_0040, len=1, size=5; `rsp_data_o` = {B,A}; err=0; rsp at cycle 4.
- Unaligned refill address 0x5180_007C → AR addr 0x5180_0040.
- Writeback of line {D1,D0} to 0x8000_0000 with `aw_ready` delayed 3 cycles and `w_ready` toggling → no W before the AW handshake; W beats D0 then D1, `wlast` on D1 only; rsp follows B.
- R beat 0 with SLVERR → `rsp_err_o`=1; next refill with OKAY → `rsp_err_o`=0.
- RLAST on beat 0 → err=1, rsp issued, unit returns to IDLE.
- `rsp_ready_i` held low for 5 cycles, then reset asserted in R state → `rsp_data_o` stable throughout the hold; after reset, all valids=0 and `req_ready_o`=1 on the next cycle.
